// File: rtl/mem_arbiter.sv
// Round-robin arbiter with bounded burst hold in front of a single-port memory.
// Issues one registered command per cycle and routes tagged read data back to its issuer.
module mem_arbiter #(
  parameter int NREQ    = 2,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int RD_LAT  = 1,
  parameter int MAX_BST = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        req_we,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]      rsp_data,
  output logic [ADDR_W-1:0]      addr,
  output logic                   wr_en,
  output logic                   rd_en,
  output logic [DATA_W-1:0]      wr_data,
  input  logic [DATA_W-1:0]      rd_data
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW  = $clog2(MAX_BST + 1);
  localparam logic [BW-1:0]  BST_MAX = BW'(MAX_BST);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] last_id;
  logic [BW-1:0]  bcnt;
  logic [IDW-1:0] rr_id;
  logic [IDW-1:0] win_id;
  logic           rr_found;
  logic           others;
  logic           hold;
  logic           win;
  logic           rd_issue;

  logic [RD_LAT:0] tag_vld;
  logic [IDW-1:0]  tag_id [RD_LAT+1];

  // A transfer happens whenever win is set: gnt only ever points at an asserted req.
  always_comb begin
    int idx;
    idx      = 0;
    rr_found = 1'b0;
    rr_id    = ptr;
    others   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx -= NREQ;
      if (!rr_found && req[idx]) begin
        rr_found = 1'b1;
        rr_id    = IDW'(idx);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (req[i] && (IDW'(i) != last_id)) others = 1'b1;
    end
    // bcnt==0 means no winner since reset; a lone requester keeps winning past MAX_BST
    hold     = (bcnt != '0) && req[last_id] && ((bcnt < BST_MAX) || !others);
    win      = !rst && (hold || rr_found);
    win_id   = hold ? last_id : rr_id;
    rd_issue = win && !req_we[win_id];
    gnt      = '0;
    if (win) gnt[win_id] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr     <= '0;
      last_id <= '0;
      bcnt    <= '0;
      addr    <= '0;
      wr_data <= '0;
      wr_en   <= 1'b0;
      rd_en   <= 1'b0;
      tag_vld <= '0;
      for (int i = 0; i <= RD_LAT; i++) tag_id[i] <= '0;
    end else begin
      wr_en     <= win && req_we[win_id];
      rd_en     <= rd_issue;
      tag_vld   <= {tag_vld[RD_LAT-1:0], rd_issue};
      tag_id[0] <= win_id;
      for (int i = 1; i <= RD_LAT; i++) tag_id[i] <= tag_id[i-1];
      if (win) begin
        addr    <= req_addr[win_id*ADDR_W +: ADDR_W];
        wr_data <= req_wdata[win_id*DATA_W +: DATA_W];
        last_id <= win_id;
        ptr     <= (win_id == LAST_ID) ? '0 : win_id + IDW'(1);
        if ((bcnt != '0) && (win_id == last_id))
          bcnt <= (bcnt == BST_MAX) ? bcnt : bcnt + BW'(1);
        else
          bcnt <= BW'(1);
      end
    end
  end

  // The last tag stage lines up with the cycle the memory presents rd_data.
  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    if (tag_vld[RD_LAT]) begin
      rsp_valid[tag_id[RD_LAT]] = 1'b1;
      rsp_data                  = rd_data;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: memory model, arbitration/response scoreboard, table vectors,
// directed multi-cycle sequences and a random soak.
module tb_mem_arbiter;

  localparam int NREQ    = 2;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;
  localparam int RD_LAT  = 1;
  localparam int MAX_BST = 4;
  localparam int QW      = 32 + 8 + DATA_W;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NREQ-1:0]        req = '0;
  logic [NREQ-1:0]        req_we = '0;
  logic [NREQ*ADDR_W-1:0] req_addr = '0;
  logic [NREQ*DATA_W-1:0] req_wdata = '0;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]      rsp_data;
  logic [ADDR_W-1:0]      addr;
  logic                   wr_en;
  logic                   rd_en;
  logic [DATA_W-1:0]      wr_data;
  logic [DATA_W-1:0]      rd_data;

  mem_arbiter #(
    .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_BST(MAX_BST)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .addr(addr), .wr_en(wr_en), .rd_en(rd_en), .wr_data(wr_data), .rd_data(rd_data)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory model ----------------
  logic [DATA_W-1:0] mem     [2**ADDR_W];
  logic [DATA_W-1:0] ref_mem [2**ADDR_W];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];
  logic              mem_init = 1'b1;

  function automatic logic [DATA_W-1:0] init_val(input int i);
    return DATA_W'(i ^ 'h5A);
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= init_val(i);
    end else if (wr_en) begin
      mem[addr] <= wr_data;
    end
    if (rd_en) rd_pipe[0] <= mem[addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign rd_data = rd_pipe[RD_LAT-1];

  // ---------------- checking helpers ----------------
  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [NREQ-1:0] oh(input int i);
    logic [NREQ-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  // ---------------- scoreboard / reference model ----------------
  int                m_ptr = 0;
  int                m_last = 0;
  int                m_bcnt = 0;
  logic              cmd_v = 1'b0;
  logic              cmd_we = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [DATA_W-1:0] cmd_wdata = '0;
  logic [QW-1:0]     exp_q[$];
  int                rsp_cnt [NREQ] = '{default: 0};

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_ptr  = 0;
      m_last = 0;
      m_bcnt = 0;
      cmd_v  = 1'b0;
    end else begin
      logic [NREQ-1:0] egnt;
      logic [QW-1:0]   e;
      int              w;
      int              others;
      // command issued for the previous cycle's transfer
      if (cmd_v) begin
        chk("cmd_wr_en", wr_en, cmd_we);
        chk("cmd_rd_en", rd_en, !cmd_we);
        chk("cmd_addr", addr, cmd_addr);
        if (cmd_we) chk("cmd_wdata", wr_data, cmd_wdata);
      end else begin
        chk("cmd_idle", {wr_en, rd_en}, 2'b00);
      end
      // read responses, in issue order at a fixed latency
      if (rsp_valid != '0) begin
        for (int i = 0; i < NREQ; i++) if (rsp_valid[i]) rsp_cnt[i]++;
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", rsp_valid, '0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_valid", rsp_valid, oh(int'(e[DATA_W +: 8])));
          chk("rsp_data", rsp_data, e[DATA_W-1:0]);
          chk("rsp_cycle", cyc, e[QW-1 -: 32]);
        end
      end else if (exp_q.size() > 0 && int'(exp_q[0][QW-1 -: 32]) <= cyc) begin
        e = exp_q.pop_front();
        chk("rsp_missing", rsp_valid, oh(int'(e[DATA_W +: 8])));
      end
      // arbitration reference
      others = 0;
      for (int i = 0; i < NREQ; i++) if (req[i] && i != m_last) others = 1;
      w = -1;
      if (m_bcnt > 0 && req[m_last] && (m_bcnt < MAX_BST || others == 0)) begin
        w = m_last;
      end else begin
        for (int k = 0; k < NREQ; k++)
          if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
      end
      egnt = '0;
      if (w >= 0) egnt[w] = 1'b1;
      chk("gnt", gnt, egnt);
      cmd_v = 1'b0;
      if (w >= 0) begin
        m_bcnt    = (m_bcnt > 0 && w == m_last) ? ((m_bcnt < MAX_BST) ? m_bcnt + 1 : m_bcnt) : 1;
        m_last    = w;
        m_ptr     = (w + 1) % NREQ;
        cmd_v     = 1'b1;
        cmd_we    = req_we[w];
        cmd_addr  = req_addr[w*ADDR_W +: ADDR_W];
        cmd_wdata = req_wdata[w*DATA_W +: DATA_W];
        if (cmd_we) ref_mem[cmd_addr] = cmd_wdata;
        else exp_q.push_back({32'(cyc + RD_LAT + 1), 8'(w), ref_mem[cmd_addr]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic we,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req[i]                         = v;
    req_we[i]                      = we;
    req_addr[i*ADDR_W +: ADDR_W]   = a;
    req_wdata[i*DATA_W +: DATA_W]  = d;
  endtask

  task automatic drain();
    req = '0;
    repeat (RD_LAT + 3) @(negedge clk);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time exhausted, finish not reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  typedef struct packed {
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
  } vec_t;

  vec_t            tbl[$];
  logic [NREQ-1:0] gobs [8];
  logic [NREQ-1:0] robs [8];
  logic [DATA_W-1:0] dobs [8];
  int base0;
  int base1;
  int ngnt;
  int waited;
  int found;
  int max_wait;
  int ngr;
  int wait_cnt [NREQ];
  logic [NREQ-1:0] g;

  initial begin
    // burst of 4, lone-requester saturation, idle hold, drop-before-grant
    for (int i = 0; i < 4; i++) tbl.push_back('{2'b11, 2'b01});
    for (int i = 0; i < 4; i++) tbl.push_back('{2'b11, 2'b10});
    tbl.push_back('{2'b11, 2'b01});
    for (int i = 0; i < 5; i++) tbl.push_back('{2'b01, 2'b01});
    tbl.push_back('{2'b11, 2'b10}); tbl.push_back('{2'b00, 2'b00});
    tbl.push_back('{2'b10, 2'b10}); tbl.push_back('{2'b01, 2'b01});
    tbl.push_back('{2'b00, 2'b00}); tbl.push_back('{2'b11, 2'b01});

    for (int i = 0; i < 2**ADDR_W; i++) ref_mem[i] = init_val(i);
    repeat (3) @(posedge clk);
    #1;
    mem_init = 1'b0;
    @(negedge clk);
    chk("reset_gnt", gnt, '0);
    chk("reset_outs", {rsp_valid, rsp_data, addr, wr_data, wr_en, rd_en}, '0);
    step();
    rst = 1'b0;

    // 1: reset while a read is in flight
    step();
    set_req(0, 1'b1, 1'b0, 8'h33, 8'h00);
    @(negedge clk);
    chk("t1_gnt", gnt, 2'b01);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("t1_rst_gnt", gnt, '0);
    chk("t1_rst_outs", {rsp_valid, rsp_data, addr, wr_data, wr_en, rd_en}, '0);
    req = '0;
    step();
    rst = 1'b0;
    base0 = rsp_cnt[0] + rsp_cnt[1];
    repeat (RD_LAT + 4) @(negedge clk);
    chk("t1_no_rsp", rsp_cnt[0] + rsp_cnt[1], base0);

    // 2: write then read the same address
    step();
    set_req(0, 1'b1, 1'b1, 8'h10, 8'hA5);
    @(negedge clk);
    chk("t2_wr_gnt", gnt, 2'b01);
    step();
    set_req(0, 1'b1, 1'b0, 8'h10, 8'h00);
    @(negedge clk);
    chk("t2_rd_gnt", gnt, 2'b01);
    chk("t2_wr_en", {wr_en, rd_en}, 2'b10);
    chk("t2_wr_addr", addr, 8'h10);
    chk("t2_wr_data", wr_data, 8'hA5);
    step();
    req = '0;
    @(negedge clk);
    chk("t2_rd_en", {wr_en, rd_en}, 2'b01);
    waited = 0;
    found  = 0;
    for (int k = 0; k < 10 && found == 0; k++) begin
      @(negedge clk);
      waited++;
      if (rsp_valid != '0) found = 1;
    end
    chk("t2_rsp_wait", waited, RD_LAT);
    chk("t2_rsp_valid", rsp_valid, 2'b01);
    chk("t2_rsp_data", rsp_data, 8'hA5);
    drain();

    // 3: table-driven arbitration from a fresh reset
    do_reset();
    for (int v = 0; v < tbl.size(); v++) begin
      step();
      for (int i = 0; i < NREQ; i++)
        set_req(i, tbl[v].req[i], 1'b0, ADDR_W'($urandom_range(0, 255)), '0);
      @(negedge clk);
      chk($sformatf("t3_gnt[%0d]", v), gnt, tbl[v].gnt);
    end
    step();
    drain();

    // 4: lone requester 1, ten reads
    base0 = rsp_cnt[0];
    base1 = rsp_cnt[1];
    ngnt  = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      set_req(0, 1'b0, 1'b0, '0, '0);
      set_req(1, 1'b1, 1'b0, ADDR_W'($urandom_range(0, 255)), '0);
      @(negedge clk);
      if (gnt == 2'b10) ngnt++;
    end
    step();
    drain();
    chk("t4_grants", ngnt, 10);
    chk("t4_rsp1", rsp_cnt[1] - base1, 10);
    chk("t4_rsp0", rsp_cnt[0] - base0, 0);

    // 5: alternating back-to-back reads of preloaded addresses
    for (int k = 0; k < 4 + RD_LAT + 1; k++) begin
      step();
      req = '0;
      if (k < 4) set_req(k % 2, 1'b1, 1'b0, ADDR_W'(k % 2 + 1), '0);
      @(negedge clk);
      gobs[k] = gnt;
      robs[k] = rsp_valid;
      dobs[k] = rsp_data;
    end
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t5_gnt[%0d]", k), gobs[k], oh(k % 2));
      chk($sformatf("t5_rsp[%0d]", k), robs[k + RD_LAT + 1], oh(k % 2));
      chk($sformatf("t5_data[%0d]", k), dobs[k + RD_LAT + 1], init_val(k % 2 + 1));
    end
    step();
    drain();

    // 6: random soak against the scoreboard
    max_wait = 0;
    ngr      = 0;
    for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      g = gnt;
      if (g != '0) ngr++;
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && !g[i]) begin
          wait_cnt[i]++;
          if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
        end else begin
          wait_cnt[i] = 0;
        end
      end
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] || g[i])
          set_req(i, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                  ADDR_W'($urandom_range(0, 15)), DATA_W'($urandom));
        else if ($urandom_range(0, 31) == 0)
          req[i] = 1'b0;
      end
    end
    step();
    drain();
    chk("t6_no_starvation", max_wait <= (NREQ - 1) * MAX_BST, 1);
    chk("t6_activity", ngr > 1000, 1);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
